// File: rtl/uart_tx_if.sv
// Byte-write handshake and serial-line signals of the UART transmitter.
// The master drives the tick and write strobe; the slave reports ready/done and the line.
interface uart_tx_if;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       tx_ready;
  logic       tx_done_tick;
  logic       tx;

  modport master (output s_tick, tx_start, din, input tx_ready, tx_done_tick, tx);
  modport slave  (input s_tick, tx_start, din, output tx_ready, tx_done_tick, tx);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with a one-byte holding register in front of the shift register,
// configurable data width, optional even/odd parity and 1/1.5/2 stop bits.
module uart_tx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [7:0] DATA_MASK      = 8'hFF >> (8 - DBIT);
  localparam logic [4:0] BIT_TICK_LAST  = 5'd15;
  localparam logic [4:0] STOP_TICK_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST       = 3'(DBIT - 1);

  // Parity is fixed when a byte enters the shift register, before it is shifted away.
  function automatic logic frame_parity(input logic [7:0] data);
    return (^(data & DATA_MASK)) ^ (PARITY_ODD != 0);
  endfunction

  state_t     state_r, state_s;
  logic [4:0] tick_r, tick_s;
  logic [2:0] bit_r, bit_s;
  logic [7:0] shift_r, shift_s;
  logic [7:0] hold_r, hold_s;
  logic       full_r, full_s;
  logic       par_r, par_s;
  logic       tx_r, tx_s;
  logic       done_r, done_s;
  logic       bit_end_s, stop_end_s;

  assign bit_end_s  = bus.s_tick && (tick_r == BIT_TICK_LAST);
  assign stop_end_s = bus.s_tick && (tick_r == STOP_TICK_LAST);

  // State register together with every datapath and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      tick_r  <= 5'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      hold_r  <= 8'd0;
      full_r  <= 1'b0;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      tick_r  <= tick_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      hold_r  <= hold_s;
      full_r  <= full_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (full_r) state_s = ST_START;
        else        state_s = ST_IDLE;
      end
      ST_START: begin
        if (bit_end_s) state_s = ST_DATA;
        else           state_s = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s && (bit_r == BIT_LAST)) begin
          if (PARITY_EN != 0) state_s = ST_PARITY;
          else                state_s = ST_STOP;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) state_s = ST_STOP;
        else           state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (stop_end_s) begin
          if (full_r) state_s = ST_START;
          else        state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    tick_s  = tick_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    hold_s  = hold_r;
    full_s  = full_r;
    par_s   = par_r;
    tx_s    = tx_r;
    done_s  = 1'b0;

    // A write is only taken while the holding register is empty, so it never
    // coincides with the transfer below (which needs it full).
    if (bus.tx_start && !full_r) begin
      hold_s = bus.din & DATA_MASK;
      full_s = 1'b1;
    end else begin
      hold_s = hold_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (full_r) begin
          shift_s = hold_r;
          par_s   = frame_parity(hold_r);
          full_s  = 1'b0;
          tick_s  = 5'd0;
          tx_s    = 1'b0;
        end else begin
          tx_s = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          tick_s = 5'd0;
          bit_s  = 3'd0;
          tx_s   = shift_r[0];
        end else if (bus.s_tick) begin
          tick_s = tick_r + 5'd1;
        end else begin
          tick_s = tick_r;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          tick_s  = 5'd0;
          shift_s = shift_r >> 1;
          if (bit_r == BIT_LAST) begin
            if (PARITY_EN != 0) tx_s = par_r;
            else                tx_s = 1'b1;
          end else begin
            bit_s = bit_r + 3'd1;
            tx_s  = shift_r[1];
          end
        end else if (bus.s_tick) begin
          tick_s = tick_r + 5'd1;
        end else begin
          tick_s = tick_r;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          tick_s = 5'd0;
          tx_s   = 1'b1;
        end else if (bus.s_tick) begin
          tick_s = tick_r + 5'd1;
        end else begin
          tick_s = tick_r;
        end
      end
      ST_STOP: begin
        if (stop_end_s) begin
          done_s = 1'b1;
          tick_s = 5'd0;
          // A queued byte starts its frame right away, with no idle cycle.
          if (full_r) begin
            shift_s = hold_r;
            par_s   = frame_parity(hold_r);
            full_s  = 1'b0;
            tx_s    = 1'b0;
          end else begin
            tx_s = 1'b1;
          end
        end else if (bus.s_tick) begin
          tick_s = tick_r + 5'd1;
        end else begin
          tick_s = tick_r;
        end
      end
      default: begin
        tx_s = 1'b1;
      end
    endcase
  end

  assign bus.tx           = tx_r;
  assign bus.tx_ready     = ~full_r;
  assign bus.tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench: four transmitter configurations share one stimulus; a
// bit-slot receiver model rebuilds each frame and compares it with the written byte.
module tb_uart_tx;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       s_tick   = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din      = 8'h00;
  logic [3:0] tx_v, ready_v, done_v;
  int tick_div = 1;
  int tick_cnt = 0;
  int done_cnt [4] = '{default: 0};
  int n_checks = 0;
  int n_fail   = 0;

  // Configurations: 0 default, 1 even parity, 2 odd parity, 3 six bits with two stop bits.
  function automatic int cfg_dbit(input int d);
    if (d == 3) return 6;
    else        return 8;
  endfunction
  function automatic int cfg_sb(input int d);
    if (d == 3) return 32;
    else        return 16;
  endfunction
  function automatic int cfg_pe(input int d);
    if (d == 1 || d == 2) return 1;
    else                  return 0;
  endfunction
  function automatic int cfg_po(input int d);
    if (d == 2) return 1;
    else        return 0;
  endfunction
  function automatic logic [7:0] mask_of(input int d);
    logic [7:0] m;
    m = 8'hFF >> (8 - cfg_dbit(d));
    return m;
  endfunction

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : gen_dut
      uart_tx_if bus ();
      assign bus.s_tick   = s_tick;
      assign bus.tx_start = tx_start;
      assign bus.din      = din;
      assign tx_v[g]      = bus.tx;
      assign ready_v[g]   = bus.tx_ready;
      assign done_v[g]    = bus.tx_done_tick;
      uart_tx #(
        .DBIT(cfg_dbit(g)), .SB_TICK(cfg_sb(g)),
        .PARITY_EN(cfg_pe(g)), .PARITY_ODD(cfg_po(g))
      ) dut (
        .clk(clk), .reset(reset), .bus(bus)
      );
    end
  endgenerate

  // Baud tick generator: one pulse every tick_div clocks, none when tick_div is 0.
  always @(negedge clk) begin
    if (tick_div == 0) begin
      s_tick = 1'b0;
    end else begin
      tick_cnt++;
      if (tick_cnt >= tick_div) begin
        tick_cnt = 0;
        s_tick   = 1'b1;
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (done_v[i] === 1'b1) done_cnt[i]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    tx_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    din      = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Receiver model: waits for the start bit, counts s_ticks, samples mid-slot.
  task automatic capture(input int d, input int budget, output logic [7:0] data,
                         output logic par, output logic start_ok, output logic stop_ok,
                         output logic stable, output int ticks, output int stop_clks);
    int w, n, c, c0, nbits, nend;
    logic t, prev;
    nbits = 1 + cfg_dbit(d) + cfg_pe(d);
    nend  = 16 * nbits + cfg_sb(d);
    data = 8'h00; par = 1'b0; start_ok = 1'b0; stop_ok = 1'b1; stable = 1'b1;
    ticks = -1; stop_clks = -1;
    w = 0;
    while (tx_v[d] !== 1'b0 && w < budget) begin
      @(posedge clk); #1; w++;
    end
    if (tx_v[d] !== 1'b0) return;
    n = 0; c = 0; c0 = 0; prev = tx_v[d];
    while (c < budget) begin
      @(posedge clk);
      t = s_tick;
      #1;
      c++;
      if (t !== 1'b1 && tx_v[d] !== prev) stable = 1'b0;
      prev = tx_v[d];
      if (t === 1'b1) begin
        n++;
        if (n == 16 * nbits) c0 = c;
        if (n < 16 * nbits && n % 16 == 8) begin
          if (n / 16 == 0)              start_ok = (tx_v[d] === 1'b0);
          else if (n / 16 <= cfg_dbit(d)) data[n / 16 - 1] = tx_v[d];
          else                          par = tx_v[d];
        end else if (n >= 16 * nbits && n < nend && tx_v[d] !== 1'b1) begin
          stop_ok = 1'b0;
        end
      end
      if (done_v[d] === 1'b1) begin
        ticks = n;
        stop_clks = c - c0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (tx_v[d] !== 1'b1) begin n_fail++; $display("FAIL reset_tx[%0d]: got %b expected 1", d, tx_v[d]); end
      n_checks++;
      if (ready_v[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 1", d, ready_v[d]); end
      n_checks++;
      if (done_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b expected 0", d, done_v[d]); end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (tx_v !== 4'hF) begin n_fail++; $display("FAIL idle_line: got %b expected 1111", tx_v); end
  endtask

  task automatic test_latency();
    do_reset();
    tick_div = 3;
    @(negedge clk);
    din = 8'($urandom);
    tx_start = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ready_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL latency_k: got ready=%b tx=%b expected ready=0 tx=1", ready_v[0], tx_v[0]);
    end
    @(negedge clk);
    tx_start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ready_v[0] !== 1'b1 || tx_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL latency_k1: got ready=%b tx=%b expected ready=1 tx=0", ready_v[0], tx_v[0]);
    end
  endtask

  task automatic test_pattern_55();
    logic [7:0] b;
    logic exp;
    do_reset();
    tick_div = 1;
    b = 8'h55;
    write_byte(b);
    for (int i = 0; i <= 160; i++) begin
      @(posedge clk); #1;
      if (i < 16)       exp = 1'b0;
      else if (i < 144) exp = b[(i - 16) / 16];
      else              exp = 1'b1;
      n_checks++;
      if (tx_v[0] !== exp) begin n_fail++; $display("FAIL pattern_tx clock %0d: got %b expected %b", i, tx_v[0], exp); end
      n_checks++;
      if (done_v[0] !== (i == 160)) begin
        n_fail++; $display("FAIL pattern_done clock %0d: got %b expected %b", i, done_v[0], (i == 160));
      end
    end
  endtask

  task automatic test_parity_known();
    logic [7:0] data;
    logic par, so, sto, st;
    int tk, sc;
    for (int d = 1; d <= 2; d++) begin
      do_reset();
      tick_div = 1;
      write_byte(8'h07);
      capture(d, 3000, data, par, so, sto, st, tk, sc);
      n_checks++;
      if (par !== (d == 1)) begin n_fail++; $display("FAIL parity_07[%0d]: got %b expected %b", d, par, (d == 1)); end
      n_checks++;
      if (tk != 176) begin n_fail++; $display("FAIL parity_len[%0d]: got %0d expected 176", d, tk); end
      n_checks++;
      if (data !== 8'h07) begin n_fail++; $display("FAIL parity_data[%0d]: got %h expected 07", d, data); end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] b, data, expd;
    logic par, so, sto, st, expp;
    int tk, sc, expt;
    for (int d = 0; d < 4; d++) begin
      do_reset();
      tick_div = (d == 3) ? 4 : int'($urandom_range(1, 3));
      for (int f = 0; f < 3; f++) begin
        b = 8'($urandom);
        expd = b & mask_of(d);
        expp = (^expd) ^ (cfg_po(d) != 0);
        expt = 16 * (1 + cfg_dbit(d) + cfg_pe(d)) + cfg_sb(d);
        write_byte(b);
        capture(d, 8000, data, par, so, sto, st, tk, sc);
        n_checks++;
        if (data !== expd) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", d, data, expd); end
        if (cfg_pe(d) != 0) begin
          n_checks++;
          if (par !== expp) begin n_fail++; $display("FAIL rand_parity[%0d]: got %b expected %b", d, par, expp); end
        end
        n_checks++;
        if (so !== 1'b1 || sto !== 1'b1) begin
          n_fail++; $display("FAIL rand_framing[%0d]: got start_ok=%b stop_ok=%b expected 1 1", d, so, sto);
        end
        n_checks++;
        if (st !== 1'b1) begin n_fail++; $display("FAIL rand_stable[%0d]: got %b expected 1", d, st); end
        n_checks++;
        if (tk != expt) begin n_fail++; $display("FAIL rand_len[%0d]: got %0d expected %0d", d, tk, expt); end
        n_checks++;
        if (sc != cfg_sb(d) * tick_div) begin
          n_fail++; $display("FAIL rand_stop_clks[%0d]: got %0d expected %0d", d, sc, cfg_sb(d) * tick_div);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done_v[d] !== 1'b0) begin n_fail++; $display("FAIL rand_done_width[%0d]: got %b expected 0", d, done_v[d]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2;
    logic p, so, sto, st, rdy2, rdy3;
    int tk1, tk2, sc, base;
    do_reset();
    tick_div = int'($urandom_range(1, 2));
    base = done_cnt[0];
    write_byte(8'hA3);
    n_checks++;
    if (ready_v[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_held: got %b expected 0", ready_v[0]); end
    @(posedge clk); #1;
    n_checks++;
    if (ready_v[0] !== 1'b1 || tx_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_transfer: got ready=%b tx=%b expected ready=1 tx=0", ready_v[0], tx_v[0]);
    end
    rdy2 = 1'b1; rdy3 = 1'b1;
    fork
      capture(0, 4000, d1, p, so, sto, st, tk1, sc);
      begin
        repeat (30) @(negedge clk);
        write_byte(8'h3C);
        rdy2 = ready_v[0];
        write_byte(8'hFF);
        rdy3 = ready_v[0];
      end
    join
    n_checks++;
    if (d1 !== 8'hA3 || tk1 != 160) begin n_fail++; $display("FAIL b2b_first: got %h/%0d expected a3/160", d1, tk1); end
    n_checks++;
    if (rdy2 !== 1'b0 || rdy3 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_queued_ready: got %b %b expected 0 0", rdy2, rdy3);
    end
    n_checks++;
    if (tx_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_no_idle: got tx=%b ready=%b expected tx=0 ready=1", tx_v[0], ready_v[0]);
    end
    capture(0, 4000, d2, p, so, sto, st, tk2, sc);
    n_checks++;
    if (d2 !== 8'h3C || tk2 != 160) begin n_fail++; $display("FAIL b2b_second: got %h/%0d expected 3c/160", d2, tk2); end
    @(negedge clk); #1;
    n_checks++;
    if (done_cnt[0] - base != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt[0] - base); end
    n_checks++;
    if (tx_v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_after: got %b expected 1", tx_v[0]); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b, data;
    logic p, so, sto, st;
    int tk, sc, base, changes;
    do_reset();
    tick_div = 1;
    b = 8'($urandom);
    b[3] = 1'b0;
    write_byte(b);
    write_byte(8'($urandom));
    base = done_cnt[0];
    repeat (66) @(negedge clk);
    n_checks++;
    if (tx_v[0] !== 1'b0 || ready_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_before: got tx=%b ready=%b expected tx=0 ready=0", tx_v[0], ready_v[0]);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got tx=%b ready=%b done=%b expected 1 1 0", tx_v[0], ready_v[0], done_v[0]);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    changes = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (tx_v[0] !== 1'b1) changes++;
    end
    n_checks++;
    if (changes != 0) begin n_fail++; $display("FAIL mid_discard: got %0d active clocks expected 0", changes); end
    n_checks++;
    if (done_cnt[0] != base) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_cnt[0] - base); end
    b = 8'($urandom);
    write_byte(b);
    capture(0, 3000, data, p, so, sto, st, tk, sc);
    n_checks++;
    if (data !== b || tk != 160 || sto !== 1'b1) begin
      n_fail++; $display("FAIL mid_recover: got %h/%0d/%b expected %h/160/1", data, tk, sto, b);
    end
  endtask

  task automatic test_tick_hold();
    logic snap;
    int changes, base, w;
    do_reset();
    tick_div = 1;
    base = done_cnt[0];
    write_byte(8'($urandom));
    repeat (40) @(negedge clk);
    @(posedge clk);
    tick_div = 0;
    @(negedge clk);
    @(posedge clk); #1;
    snap = tx_v[0];
    changes = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (tx_v[0] !== snap) changes++;
    end
    n_checks++;
    if (changes != 0) begin n_fail++; $display("FAIL hold_tx: got %0d changes expected 0", changes); end
    n_checks++;
    if (done_cnt[0] != base) begin n_fail++; $display("FAIL hold_done: got %0d pulses expected 0", done_cnt[0] - base); end
    tick_div = 1;
    w = 0;
    while (done_cnt[0] == base && w < 400) begin
      @(negedge clk); #1; w++;
    end
    n_checks++;
    if (done_cnt[0] - base != 1) begin n_fail++; $display("FAIL hold_resume: got %0d pulses expected 1", done_cnt[0] - base); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_pattern_55();
    test_parity_known();
    test_random_frames();
    test_back_to_back();
    test_reset_midframe();
    test_tick_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame; legal range 5..8.
REQ-002 Parameter SB_TICK, default 16: s_tick count for the stop period; 16/24/32 give 1/1.5/2 stop bits.
REQ-003 Parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 s_tick  input  1  one-clock enable pulse at 16x the baud rate.
REQ-008 tx_start  input  1  write strobe; accepted only while tx_ready=1.
REQ-009 din  input  8  byte to send; bits above DBIT-1 are ignored.
REQ-010 tx_ready  output  1  1 = holding register empty, so a write is accepted.
REQ-011 tx_done_tick  output  1  one-clock pulse at the end of each frame.
REQ-012 tx  output  1  serial line, driven from a register; idle level 1.

Function
REQ-013 The block SHALL hold one byte in a holding register plus one in a shift register, so a second byte can be queued while a frame is in flight.
REQ-014 tx_start=1 with tx_ready=1 SHALL load din into the holding register and set it full; tx_start with tx_ready=0 SHALL be ignored and SHALL NOT corrupt the held byte.
REQ-015 tx_ready SHALL equal the inverse of the holding-register full flag, taken directly from that register.
REQ-016 The FSM SHALL have five states: idle, start, data, parity, stop.
REQ-017 idle with holding register full: at the next edge, go to start, move the held byte to the shift register, clear the full flag, drive tx=0, clear the tick counter.
REQ-018 start: drive tx=0 for 16 s_ticks; on the s_tick with counter=15, go to data, clear the tick and bit counters, and drive tx with shift register bit 0.
REQ-019 data: bits go out LSB first, 16 s_ticks each; on the s_tick with counter=15, shift right and increment the bit counter.
REQ-020 data exit, after bit DBIT-1 completes: go to parity if PARITY_EN=1, else go to stop.
REQ-021 parity: drive the XOR of the DBIT data bits (inverted when PARITY_ODD=1) for 16 s_ticks, then go to stop.
REQ-022 stop: drive tx=1 for SB_TICK s_ticks; the tick counter SHALL be 5 bits wide.
REQ-023 On the s_tick with counter=SB_TICK-1, tx_done_tick SHALL pulse for exactly one clock.
REQ-024 On that same final stop tick, if the holding register is full, the FSM SHALL go directly to start with no idle cycle, using the REQ-017 actions; otherwise it SHALL go to idle.
REQ-025 Counters SHALL advance only on s_tick; without s_tick, tx and the state SHALL hold indefinitely.
REQ-026 Latency: tx_start sampled at edge k, with the block idle and the holding register empty, SHALL give tx=0 after edge k+1.
REQ-027 Frame length: 16*(1+DBIT+PARITY_EN)+SB_TICK s_ticks.
REQ-028 A tx_start accepted on the same edge that the holding register is transferred out is not possible by construction (REQ-015); no special case is required.

Reset
REQ-029 On reset, asynchronously: state=idle, tx=1, tx_ready=1, tx_done_tick=0, all counters and the shift register 0, holding register empty.
REQ-030 Reset mid-frame SHALL abort the frame; tx SHALL return to 1 immediately, no tx_done_tick SHALL occur, and any queued byte SHALL be discarded.

Verification
REQ-031 Defaults, s_tick every clock, din=0x55: tx=0 for 16 clocks, then 1,0,1,0,1,0,1,0 for 16 clocks each, then 1 for 16 clocks; tx_done_tick on the 160th tick.
REQ-032 PARITY_EN=1, even, din=0x07: parity bit=1; with PARITY_ODD=1, parity bit=0; frame length 176 ticks.
REQ-033 Write 0xA3, then 0x3C while the first frame is in flight: tx_ready=0 until the transfer at the 0xA3 frame start; the 0x3C start bit begins the clock after the 0xA3 final stop tick; exactly two tx_done_tick pulses.
REQ-034 Third write while holding register full: ignored, and the second byte is transmitted unchanged.
REQ-035 Reset asserted during data bit 3: tx=1 immediately, tx_ready=1, no tx_done_tick; a new write afterward produces a correct full frame.
REQ-036 SB_TICK=32, s_tick every 4th clock: stop period=128 clocks, tx stable between ticks.
